// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the 7-stage core's sequencing control.
package core_ctrl_pkg;

    typedef enum logic [1:0] {RUN, FLUSH, MDWAIT} ctrl_state_e;

    localparam int         FLUSH_CYCLES_DEF = 2;
    localparam int         REG_AW           = 5;
    localparam logic [4:0] REG_X0           = 5'd0;
    localparam logic [1:0] PC_SEQ           = 2'b00;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } push_t;

endpackage

// File: rtl/reg_scoreboard.sv
// In-flight writer counters per architectural register, with two busy read ports.
module reg_scoreboard
    import core_ctrl_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_inc_en,
    input  logic [REG_AW-1:0] i_inc_rd,
    input  logic              i_ret_en,
    input  logic [REG_AW-1:0] i_ret_rd,
    input  logic              i_kill_en,
    input  logic [REG_AW-1:0] i_kill_rd,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_busy1,
    output logic              o_busy2
);

    logic [NREG-1:0][CNT_W-1:0] r_cnt;
    // Two guard bits expose over/underflow before the wrap back to CNT_W bits.
    logic [NREG-1:0][CNT_W+1:0] w_ext;

    always_comb begin
        w_ext = '0;
        for (int r = 1; r < NREG; r++) begin
            w_ext[r] = {2'b00, r_cnt[r]}
                     + (CNT_W+2)'(i_inc_en  && (i_inc_rd  == REG_AW'(r)))
                     - (CNT_W+2)'(i_ret_en  && (i_ret_rd  == REG_AW'(r)))
                     - (CNT_W+2)'(i_kill_en && (i_kill_rd == REG_AW'(r)));
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
        end else begin
            for (int r = 1; r < NREG; r++)
                r_cnt[r] <= w_ext[r][CNT_W-1:0];
        end
    end

    assign o_busy1 = (r_cnt[i_rs1] != '0);
    assign o_busy2 = (r_cnt[i_rs2] != '0);

    for (genvar g = 0; g < NREG; g++) begin : g_range_chk
        a_cnt_range: assert property (@(posedge clk) disable iff (!nrst)
            w_ext[g][CNT_W+1:CNT_W] == 2'b00);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for the in-order core: RAW bubbles, redirect squash, mul/div freeze.
// Define HAZ_STATS_EN to add free-running stall/redirect/MDWAIT cycle counters.
module pipe_hazard_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int NREG         = 32,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        dec_valid3,
    input  logic [4:0]  rs1_3,
    input  logic [4:0]  rs2_3,
    input  logic        use_rs1_3,
    input  logic        use_rs2_3,
    input  logic        we3,
    input  logic [4:0]  rd3,
    input  logic [1:0]  redirect5,
    input  logic        md_busy,
    input  logic        ret_we6,
    input  logic [4:0]  ret_rd6,
    output logic        stall_fe,
    output logic        stall_dec,
    output logic        bubble_iss,
    output logic        flush_fe,
    output logic        flush_dec,
    output logic        flush_iss,
    output logic        issue_fire
`ifdef HAZ_STATS_EN
   ,output logic [31:0] stat_stall,
    output logic [31:0] stat_flush,
    output logic [31:0] stat_mdwait
`endif
);

    ctrl_state_e r_state, w_nstate;
    logic [2:0]  r_flush_cnt, w_ncnt;
    push_t       r_last_push;

    logic w_redirect, w_hazard, w_busy1, w_busy2, w_push;
    logic w_stall, w_bubble, w_flush_fd, w_flush_iss, w_fire;

    assign w_redirect = (redirect5 != PC_SEQ);
    assign w_hazard   = dec_valid3 & ((use_rs1_3 & (rs1_3 != REG_X0) & w_busy1) |
                                      (use_rs2_3 & (rs2_3 != REG_X0) & w_busy2));
    assign w_push     = w_fire & we3 & (rd3 != REG_X0);

    // MDWAIT with md_busy low behaves exactly like RUN, so the two share a branch.
    always_comb begin
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_flush_fd  = 1'b0;
        w_flush_iss = 1'b0;
        w_fire      = 1'b0;
        w_nstate    = r_state;
        w_ncnt      = r_flush_cnt;
        if (w_redirect) begin
            w_flush_fd  = 1'b1;
            w_flush_iss = 1'b1;
            w_ncnt      = 3'(FLUSH_CYCLES - 1);
            w_nstate    = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end else if (r_state == FLUSH) begin
            w_flush_fd = 1'b1;
            w_ncnt     = r_flush_cnt - 3'd1;
            if (w_ncnt == 3'd0) w_nstate = RUN;
        end else if (md_busy) begin
            w_stall  = 1'b1;
            w_nstate = MDWAIT;
        end else begin
            w_nstate = RUN;
            if (w_hazard) begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
            end else begin
                w_fire = dec_valid3;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
            r_last_push <= '0;
        end else begin
            r_state     <= w_nstate;
            r_flush_cnt <= w_ncnt;
            r_last_push <= w_redirect ? push_t'('0) : '{valid: w_push, rd: rd3};
        end
    end

    reg_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) u_sb (
        .clk       (clk),
        .nrst      (nrst),
        .i_inc_en  (w_push),
        .i_inc_rd  (rd3),
        .i_ret_en  (ret_we6),
        .i_ret_rd  (ret_rd6),
        .i_kill_en (w_redirect & r_last_push.valid),
        .i_kill_rd (r_last_push.rd),
        .i_rs1     (rs1_3),
        .i_rs2     (rs2_3),
        .o_busy1   (w_busy1),
        .o_busy2   (w_busy2)
    );

    // Outputs are forced low for the whole time reset is asserted, not just at the edge.
    assign stall_fe   = nrst & w_stall;
    assign stall_dec  = nrst & w_stall;
    assign bubble_iss = nrst & w_bubble;
    assign flush_fe   = nrst & w_flush_fd;
    assign flush_dec  = nrst & w_flush_fd;
    assign flush_iss  = nrst & w_flush_iss;
    assign issue_fire = nrst & w_fire;

`ifdef HAZ_STATS_EN
    logic [31:0] r_stat_stall, r_stat_flush, r_stat_mdwait;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_stat_stall  <= '0;
            r_stat_flush  <= '0;
            r_stat_mdwait <= '0;
        end else begin
            r_stat_stall  <= r_stat_stall  + 32'(w_bubble);
            r_stat_flush  <= r_stat_flush  + 32'(w_redirect);
            r_stat_mdwait <= r_stat_mdwait + 32'(r_state == MDWAIT);
        end
    end

    assign stat_stall  = r_stat_stall;
    assign stat_flush  = r_stat_flush;
    assign stat_mdwait = r_stat_mdwait;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       dec_valid3 = 1'b0, use_rs1_3 = 1'b0, use_rs2_3 = 1'b0, we3 = 1'b0;
    logic [4:0] rs1_3 = '0, rs2_3 = '0, rd3 = '0, ret_rd6 = '0;
    logic [1:0] redirect5 = '0;
    logic       md_busy = 1'b0, ret_we6 = 1'b0;
    logic       stall_fe, stall_dec, bubble_iss, flush_fe, flush_dec, flush_iss, issue_fire;

    int errors = 0;
    int checks = 0;

    // Model state: outstanding writers per register, flush cycles still owed, stage-4 writer.
    int m_sb [32] = '{default: 0};
    int m_left = 0;
    int m_last = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .NREG(32), .CNT_W(2)) dut (
        .clk(clk), .nrst(nrst),
        .dec_valid3(dec_valid3), .rs1_3(rs1_3), .rs2_3(rs2_3),
        .use_rs1_3(use_rs1_3), .use_rs2_3(use_rs2_3), .we3(we3), .rd3(rd3),
        .redirect5(redirect5), .md_busy(md_busy), .ret_we6(ret_we6), .ret_rd6(ret_rd6),
        .stall_fe(stall_fe), .stall_dec(stall_dec), .bubble_iss(bubble_iss),
        .flush_fe(flush_fe), .flush_dec(flush_dec), .flush_iss(flush_iss),
        .issue_fire(issue_fire)
    );

    // {stall_fe, stall_dec, bubble_iss, flush_fe, flush_dec, flush_iss, issue_fire}
    wire [6:0] act = {stall_fe, stall_dec, bubble_iss, flush_fe, flush_dec, flush_iss, issue_fire};

    function automatic logic [6:0] model_out();
        bit haz;
        if (!nrst) return 7'b0;
        haz = dec_valid3 && ((use_rs1_3 && rs1_3 != 0 && m_sb[rs1_3] != 0) ||
                             (use_rs2_3 && rs2_3 != 0 && m_sb[rs2_3] != 0));
        if (redirect5 != 2'b00) return 7'b0001110;
        if (m_left > 0)         return 7'b0001100;
        if (md_busy)            return 7'b1100000;
        if (haz)                return 7'b1110000;
        return {6'b0, dec_valid3};
    endfunction

    function automatic bit model_fire();
        logic [6:0] o;
        o = model_out();
        return o[0];
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int r = 0; r < 32; r++) m_sb[r] <= 0;
            m_left <= 0;
            m_last <= 0;
        end else begin
            for (int r = 1; r < 32; r++)
                m_sb[r] <= m_sb[r]
                         + ((model_fire() && we3 && rd3 == r) ? 1 : 0)
                         - ((ret_we6 && ret_rd6 == r) ? 1 : 0)
                         - ((redirect5 != 0 && m_last == r) ? 1 : 0);
            m_last <= (redirect5 == 0 && model_fire() && we3) ? int'(rd3) : 0;
            m_left <= (redirect5 != 0) ? FC - 1 : (m_left > 0 ? m_left - 1 : 0);
        end
    end

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b need %b", name, got, exp);
        end
    endtask

    always @(negedge clk) check($sformatf("outs@%0t", $time), act, model_out());

    task automatic step(input logic v, input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2, input logic we,
                        input logic [4:0] rd, input logic [1:0] rdr, input logic md,
                        input logic rwe, input logic [4:0] rrd);
        @(posedge clk);
        #1;
        dec_valid3 = v;  rs1_3 = s1; use_rs1_3 = u1; rs2_3 = s2; use_rs2_3 = u2;
        we3 = we; rd3 = rd; redirect5 = rdr; md_busy = md; ret_we6 = rwe; ret_rd6 = rrd;
    endtask

    task automatic hand(input string name, input logic [6:0] exp);
        #1;
        check(name, act, exp);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    initial begin
        #2 check("reset_outs", act, 7'b0);
        @(posedge clk); @(posedge clk); #1 nrst = 1'b1;

        // RAW: x5 writer, then dependent reader bubbles until x5 retires
        step(1, 1, 1, 0, 0, 1, 5, 2'b00, 0, 0, 0);  hand("raw_issue", 7'b0000001);
        step(1, 5, 1, 1, 1, 1, 6, 2'b00, 0, 0, 0);  hand("raw_bub1", 7'b1110000);
        step(1, 5, 1, 1, 1, 1, 6, 2'b00, 0, 0, 0);
        step(1, 5, 1, 1, 1, 1, 6, 2'b00, 0, 1, 5);  hand("raw_bub3", 7'b1110000);
        step(1, 5, 1, 1, 1, 1, 6, 2'b00, 0, 0, 0);  hand("raw_fire", 7'b0000001);
        step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 6);
        step(1, 5, 1, 6, 1, 0, 0, 2'b00, 0, 0, 0);  hand("raw_clear", 7'b0000001);

        // x0 destination is never tracked
        step(1, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0);  hand("x0_read", 7'b0000001);

        // redirect squashes the stage-4 writer of x7
        step(1, 0, 0, 0, 0, 1, 7, 2'b00, 0, 0, 0);
        step(1, 7, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0);  hand("redir_cyc", 7'b0001110);
        step(1, 7, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);  hand("flush_cyc2", 7'b0001100);
        step(1, 7, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);  hand("post_flush", 7'b0000001);

        // simultaneous issue and retire of x3; unused rs1 ignored; rs2 hazard
        step(1, 0, 0, 0, 0, 1, 3, 2'b00, 0, 0, 0);
        step(1, 3, 0, 0, 0, 1, 3, 2'b00, 0, 1, 3);  hand("same_reg", 7'b0000001);
        step(1, 0, 0, 3, 1, 0, 0, 2'b00, 0, 1, 3);  hand("rs2_haz", 7'b1110000);
        step(1, 0, 0, 3, 1, 0, 0, 2'b00, 0, 0, 0);  hand("rs2_clear", 7'b0000001);

        // mul/div busy for five cycles
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        hand("md_stall5", 7'b1100000);
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);  hand("md_release", 7'b0000001);

        // redirect during the third busy cycle takes over
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0);  hand("md_redir", 7'b0001110);
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);  hand("md_flush", 7'b0001100);
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

        // reset mid-flush with two writers of x9 in flight
        step(1, 0, 0, 0, 0, 1, 9, 2'b00, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 9, 2'b00, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
        idle();
        #1 redirect5 = 2'b01; dec_valid3 = 1'b1; md_busy = 1'b1;
        #1 nrst = 1'b0;
        #1 check("rst_async", act, 7'b0);
        @(posedge clk); #1;
        redirect5 = 2'b00; dec_valid3 = 1'b0; md_busy = 1'b0;
        nrst = 1'b1;
        step(1, 9, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);  hand("rst_cleared", 7'b0000001);
        idle();
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 7-stage in-order core.
- Tracks in-flight register writes in a scoreboard and stalls the front end/decode on RAW hazards by injecting bubbles into issue.
- Squashes wrong-path instructions on an execute-stage PC redirect.
- Freezes the front half while the multicycle mul/div unit is busy.
- Sits beside the stage pipes; drives their stall/flush inputs only.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_fe/flush_dec stay high after a redirect (covers instruction-memory latency); legal 1..7.
- NREG, 32, architectural register count; x0 never tracked.
- CNT_W, 2, width of per-register in-flight counter; max 3 writers in stages 4..6.

Ports:
- clk  in  1  core clock
- nrst  in  1  asynchronous active-low reset
- dec_valid3  in  1  stage-3 holds a valid instruction
- rs1_3  in  5  stage-3 source 1 address
- rs2_3  in  5  stage-3 source 2 address
- use_rs1_3  in  1  instruction reads rs1
- use_rs2_3  in  1  instruction reads rs2
- we3  in  1  instruction writes rd
- rd3  in  5  destination address
- redirect5  in  2  pcselect from execute; nonzero = taken branch/jump
- md_busy  in  1  mul/div unit occupying execute
- ret_we6  in  1  commit writes register file this cycle
- ret_rd6  in  5  commit destination
- stall_fe  out  1  hold PC and IF pipe
- stall_dec  out  1  hold decode pipe
- bubble_iss  out  1  issue pipe loads NOP (we=0, pcselect=0)
- flush_fe  out  1  invalidate IF pipe
- flush_dec  out  1  invalidate decode pipe
- flush_iss  out  1  invalidate issue pipe contents
- issue_fire  out  1  stage-3 instruction advances this cycle

Behaviour:
- Reset (async, nrst=0): all outputs 0; all counters 0; state RUN; flush_cnt 0; last_push cleared.
- Interface: one clock; reset is asynchronous and active-low.
- States:
  - RUN
  - FLUSH: flush_cnt counts down from FLUSH_CYCLES-1.
  - MDWAIT
- hazard = dec_valid3 & ((use_rs1_3 & rs1_3!=0 & cnt[rs1_3]!=0) | (use_rs2_3 & rs2_3!=0 & cnt[rs2_3]!=0)). Combinational.
- Priority each cycle: redirect5!=0 > md_busy > hazard.
- RUN:
  - redirect: flush_fe, flush_dec, flush_iss=1 same cycle; go FLUSH with flush_cnt=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, return to RUN.
  - md_busy: stall_fe, stall_dec=1, bubble_iss=0 (issue holds); go MDWAIT.
  - hazard: stall_fe, stall_dec, bubble_iss=1.
  - else: issue_fire=dec_valid3.
- FLUSH: flush_fe, flush_dec=1; issue_fire=0; decrement flush_cnt; at 0 go RUN. A new redirect restarts the count.
- MDWAIT: stall_fe, stall_dec=1 while md_busy; when md_busy falls, go RUN the same cycle (outputs evaluate as RUN). A redirect in MDWAIT takes priority and goes to FLUSH.
- Scoreboard update, one registered step per cycle: cnt[r] <= cnt[r] + inc - dec_ret - dec_kill.
  - inc: issue_fire & we3 & rd3==r.
  - dec_ret: ret_we6 & ret_rd6==r.
  - dec_kill: redirect & last_push.valid & last_push.rd==r. Removes the squashed stage-4 writer.
  - All three may hit the same register; net applied arithmetically; r=0 ignored.
- last_push <= {issue_fire & we3 & rd3!=0, rd3}; cleared on redirect.
- Counter over/underflow: assertion error in simulation; RTL wraps silently.
- Retire of an untracked register (cnt=0) is illegal.

Optional Feature:
- HAZ_STATS_EN defined: adds outputs stat_stall (32), stat_flush (32), stat_mdwait (32).
  - Free-running counts of hazard-stall cycles, redirect events and MDWAIT cycles.
  - Reset to 0; wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package core_ctrl_pkg:
  - state enum {RUN, FLUSH, MDWAIT}
  - FLUSH_CYCLES default
  - REG_X0 constant
  - pcselect encoding constants (PC_SEQ=2'b00)
- Sub-module reg_scoreboard: counter array, inc/dec ports, two read ports for rs1/rs2. The controller FSM stays in the top.

Test Plan:
- Back-to-back RAW: add x5 issues, next cycle add x6,x5,x1 -> bubble_iss=1 for 3 cycles until ret_we6 rd=5; then issue_fire=1; cnt[5]=0 after.
- x0 destination: we3=1, rd3=0, then read x0 -> no stall, cnt unchanged.
- Redirect kill: issue write x7, next cycle redirect5=2'b01 -> flush_iss=1, cnt[7] returns 0; flush_fe/flush_dec high exactly 2 cycles.
- Simultaneous: issue x3 while ret_we6 rd=3 and cnt[3]=1 -> cnt[3] stays 1, no underflow.
- md_busy 5 cycles -> stall_fe/stall_dec high 5 cycles, bubble_iss=0; redirect during cycle 3 -> FLUSH entered, stalls drop.
- nrst pulled low mid-FLUSH with cnt[9]=2 -> all outputs 0 immediately, cnt cleared, state RUN after release.
